// File: rtl/mips_data_ram.sv
// Unified MIPS instruction/data memory: DEPTH x 32-bit words, byte addressed.
// Read is combinational; stores happen on the rising clock edge.
module mips_data_ram #(
  parameter int    DEPTH     = 256,
  parameter string INIT_FILE = "add.txt"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] sa,
  input  logic [31:0] sin,
  input  logic        sw,
  output logic [31:0] sout
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Power-up contents of one word. The image named by INIT_FILE is compiled in
  // here so the memory comes up loaded without any file access at elaboration.
  function automatic logic [31:0] init_word(input int idx);
    logic [31:0] w;
    w = 32'h0000_0000;
    if (INIT_FILE == "add.txt") begin
      case (idx)
        0:       w = 32'b10001100000001110000000000111000;  // lw $7,56($0)
        3:       w = 32'hFFFF_FFF9;                         // -7
        default: w = 32'h0000_0000;
      endcase
    end
    return w;
  endfunction

  logic [29:0]      word_idx;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             wr_en;
  logic [31:0]      rd_words [DEPTH];

  assign word_idx = sa[31:2];
  assign in_range = ({2'b00, word_idx} < 32'(DEPTH));
  assign idx      = word_idx[IDX_W-1:0];
  // An X/Z strobe fails the if-test below and so never writes.
  assign wr_en    = rst_n & sw & in_range;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [31:0] word_reg = init_word(gi);

      // Contents are deliberately not reset: they survive rst_n assertion.
      always_ff @(posedge clk) begin
        if (wr_en && (idx == IDX_W'(gi))) begin
          word_reg <= sin;
        end
      end

      assign rd_words[gi] = word_reg;
    end
  endgenerate

  always_comb begin
    sout = 32'h0000_0000;
    if (rst_n && in_range) begin
      sout = rd_words[idx];
    end
  end

endmodule

// File: tb/tb_mips_data_ram.sv
// Directed table-driven bench for mips_data_ram plus hand sequences for the
// read-during-write and mid-run reset cases.
module tb_mips_data_ram;

  logic        clk;
  logic        rst_n;
  logic [31:0] sa;
  logic [31:0] sin;
  logic        sw;
  logic [31:0] sout;

  int checks = 0;
  int errors = 0;

  mips_data_ram #(.DEPTH(256), .INIT_FILE("add.txt")) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sa    (sa),
    .sin   (sin),
    .sw    (sw),
    .sout  (sout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] sa;
    logic [31:0] sin;
    logic        sw;
    int          edges;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] exp);
    checks++;
    if (sout !== exp) begin
      errors++;
      $display("FAIL %s: sout=%h expected=%h", name, sout, exp);
    end else begin
      $display("ok   %s: sa=%h sout=%h", name, sa, sout);
    end
  endtask

  initial begin
    vecs[0]  = '{"rd_w0",        32'd0,    32'd0,  1'b0, 0, 32'h8C07_0038};
    vecs[1]  = '{"rd_w3",        32'd12,   32'd0,  1'b0, 0, 32'hFFFF_FFF9};
    vecs[2]  = '{"rd_b13",       32'd13,   32'd0,  1'b0, 0, 32'hFFFF_FFF9};
    vecs[3]  = '{"rd_b14",       32'd14,   32'd0,  1'b0, 0, 32'hFFFF_FFF9};
    vecs[4]  = '{"rd_b15",       32'd15,   32'd0,  1'b0, 0, 32'hFFFF_FFF9};
    vecs[5]  = '{"rd_w1_zero",   32'd4,    32'd0,  1'b0, 0, 32'h0};
    vecs[6]  = '{"nowr_sw0",     32'd12,   32'd69, 1'b0, 2, 32'hFFFF_FFF9};
    vecs[7]  = '{"wr_oor_1024",  32'd1024, 32'd5,  1'b1, 1, 32'h0};
    vecs[8]  = '{"no_alias_w0",  32'd0,    32'd0,  1'b0, 0, 32'h8C07_0038};
    vecs[9]  = '{"rd_oor_big",   32'h4000_0000, 32'd0, 1'b0, 0, 32'h0};
    vecs[10] = '{"rd_last_w",    32'd1020, 32'd0,  1'b0, 0, 32'h0};
    vecs[11] = '{"wr_last_w",    32'd1023, 32'hA5A5_5A5A, 1'b1, 1, 32'hA5A5_5A5A};
    vecs[12] = '{"wr_w5_unal",   32'd22,   32'h1234_5678, 1'b1, 1, 32'h1234_5678};
    vecs[13] = '{"rd_w5",        32'd20,   32'd0,  1'b0, 0, 32'h1234_5678};

    rst_n = 1'b0;
    sa    = 32'd0;
    sin   = 32'd0;
    sw    = 1'b0;
    #3;
    check("reset_sout", 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #10;

    for (int i = 0; i < 14; i++) begin
      sa  = vecs[i].sa;
      sin = vecs[i].sin;
      sw  = vecs[i].sw;
      for (int e = 0; e < vecs[i].edges; e++) begin
        @(posedge clk);
        #1;
      end
      #1;
      check(vecs[i].name, vecs[i].exp);
      sw = 1'b0;
    end

    // Read-during-write on word 3: old value before the edge, new after.
    @(negedge clk);
    sa  = 32'd12;
    sin = 32'd69;
    sw  = 1'b1;
    #1;
    check("rdw_before", 32'hFFFF_FFF9);
    @(posedge clk);
    #1;
    check("rdw_after", 32'd69);
    sw = 1'b0;

    // Mid-run asynchronous reset with a store held: suppressed, contents kept.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_zero", 32'h0);
    sa  = 32'd12;
    sin = 32'd7;
    sw  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_held_zero", 32'h0);
    sw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_retained", 32'd69);

    // Write allowed on the first edge after release.
    sin = 32'hDEAD_BEEF;
    sw  = 1'b1;
    @(posedge clk);
    #1;
    check("first_wr_after_rst", 32'hDEAD_BEEF);
    sw = 1'b0;
    sa = 32'd0;
    #1;
    check("w0_intact", 32'h8C07_0038);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_data_ram.md
Name: mips_data_ram

Overview:
- Word-organised, byte-addressed unified memory for the MIPS processor. It holds the preloaded program/data image.
- Read is combinational (asynchronous). Write is synchronous on the rising clock edge when the store strobe is high.
- Serves instruction fetch and load/store data through a single address port.

Parameters:
- DEPTH, 256, number of 32-bit words; byte address space is DEPTH*4.
- INIT_FILE, "add.txt", binary-format text image loaded at elaboration, one 32-bit word per line, starting at word 0.

Ports:
- clk  input  1  system clock; writes occur on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sa  input  32  byte address.
- sin  input  32  write data.
- sw  input  1  store/write enable, active high.
- sout  output  32  read data.

Behaviour:
- Storage: DEPTH x 32-bit array.
  - Initialised from INIT_FILE at time 0.
  - Words not covered by the file are 0.
- Addressing:
  - Word index = sa[31:2]; sa[1:0] are ignored, so unaligned addresses map to the containing word.
  - In range when word index < DEPTH. No wrap-around.
- Read:
  - sout = mem[sa[31:2]], combinational, zero latency; follows sa within the same delta.
  - Out-of-range address: sout = 32'h0000_0000.
- Write:
  - On posedge clk with rst_n=1, sw=1 and address in range: mem[index] <= sin.
  - New value appears on sout immediately after that edge (same address held).
  - sw=0, or an out-of-range address: no state change.
  - sw=X/Z is treated as no write.
- Read-during-write, same address: sout shows the old value before the edge and the new value after it. No bypass of sin.
- Reset (rst_n=0, asynchronous):
  - sout forced to 0 immediately, independent of clk.
  - All writes are suppressed while rst_n=0.
  - Memory contents are NOT cleared or reloaded; they are retained across reset.
- Reset release: sout resumes combinational read of the current sa. The first write can occur on the first rising edge with rst_n=1.
- Default image (add.txt), required contents:
  - word 0 (byte 0) = 32'b10001100000001110000000000111000 (0x8C070038, lw $7,56($0)).
  - word 3 (byte 12) = 32'hFFFFFFF9 (-7).
- No handshake. Single port. One access per cycle.

Test Plan:
- rst_n=1, sa=0, sw=0, wait 10 -> sout=0x8C070038.
- sa=12 -> sout=0xFFFFFFF9 (-7). Same address with sa=13/14/15 -> same value.
- sa=12, sin=69, sw=0, two clock edges -> sout still 0xFFFFFFF9.
- sa=12, sin=69, sw=1, one rising edge -> sout=69 after the edge. Before the edge, sout=0xFFFFFFF9.
- sa=DEPTH*4 (1024), sw=1, sin=5, one edge -> sout=0. Then sa=0 -> still 0x8C070038 (no aliasing).
- Mid-run: assert rst_n=0 between edges -> sout=0 immediately. Hold sw=1, sin=7, sa=12 over two edges. Release rst_n -> sout=69 (write suppressed, contents retained).
